fp27_to_fix: RTL and testbench



---
 rtl/fp27_to_fix.sv | 154 +++++++++++++++
 tb/tb_fp27_to_fix.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fp27_to_fix.sv
// fp27 -> signed fixed-point converter, 3-stage valid/ready pipeline with a single global advance.
// Optional build macro FP2FIX_ROUND_EN: round-to-nearest (ties away from zero) on right shifts; default truncates.
module fp27_to_fix #(
    parameter int OUT_W     = 32,
    parameter int FRAC_BITS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [26:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_ovf,
    output logic             out_udf
);

    // Wide enough to hold a full 19-bit mantissa shifted to just below the overflow limit
    localparam int LW = OUT_W + 20;

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // S1 registers
    logic              s1_valid;
    logic              s1_sign;
    logic [18:0]       s1_m;
    logic [9:0]        s1_sh;
    logic              s1_zero;
    logic              s1_inf;

    // S2 registers
    logic              s2_valid;
    logic              s2_sign;
    logic [OUT_W:0]    s2_mag;
    logic              s2_ovf;
    logic              s2_zero;
    logic              s2_inf;

    logic [7:0] in_exp;
    logic [9:0] sh_next;
    assign in_exp  = in_data[25:18];
    assign sh_next = {2'b00, in_exp} - 10'd145 + 10'(FRAC_BITS);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_m     <= '0;
            s1_sh    <= '0;
            s1_zero  <= 1'b0;
            s1_inf   <= 1'b0;
        end else if (adv) begin
            s1_valid <= in_valid;
            s1_sign  <= in_data[26];
            s1_m     <= {1'b1, in_data[17:0]};
            s1_sh    <= sh_next;
            s1_zero  <= (in_exp == 8'd0);
            s1_inf   <= (in_exp == 8'hFF);
        end
    end

    // S2 shift: s1_sh is a two's-complement shift, bit 9 is the sign
    logic          sh_neg;
    logic [9:0]    rs;
    logic          big_sh;
    logic [LW-1:0] lsh;
    logic [18:0]   rq;
    logic          rnd;
    logic [LW-1:0] rsh;
    logic [LW-1:0] shifted;
    logic          ovf_pre;

    assign sh_neg = s1_sh[9];
    assign rs     = 10'd0 - s1_sh;
    assign big_sh = !sh_neg && (s1_sh[8:0] >= 9'(OUT_W));
    assign lsh    = LW'(s1_m) << s1_sh[6:0];
    assign rq     = (rs > 10'd18) ? 19'd0 : (s1_m >> rs[4:0]);

`ifdef FP2FIX_ROUND_EN
    logic [18:0] rv;
    assign rv  = s1_m >> (rs[4:0] - 5'd1);
    assign rnd = (rs <= 10'd19) ? rv[0] : 1'b0;
`else
    assign rnd = 1'b0;
`endif

    assign rsh     = LW'(rq) + LW'(rnd);
    assign shifted = sh_neg ? rsh : lsh;
    assign ovf_pre = big_sh || (|shifted[LW-1:OUT_W]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_mag   <= '0;
            s2_ovf   <= 1'b0;
            s2_zero  <= 1'b0;
            s2_inf   <= 1'b0;
        end else if (adv) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_mag   <= shifted[OUT_W:0];
            s2_ovf   <= ovf_pre;
            s2_zero  <= s1_zero;
            s2_inf   <= s1_inf;
        end
    end

    // S3: a magnitude of exactly 2^(OUT_W-1) is only representable when negative
    logic             mag_top;
    logic             mag_low_nz;
    logic             sat;
    logic [OUT_W-1:0] data_next;
    logic             ovf_next;
    logic             udf_next;

    assign mag_top    = s2_mag[OUT_W-1];
    assign mag_low_nz = |s2_mag[OUT_W-2:0];
    assign sat        = s2_inf || s2_ovf || s2_mag[OUT_W] ||
                        (mag_top && (!s2_sign || mag_low_nz));

    always_comb begin
        data_next = '0;
        ovf_next  = 1'b0;
        udf_next  = 1'b0;
        if (s2_zero) begin
            data_next = '0;
        end else if (sat) begin
            data_next = s2_sign ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
            ovf_next  = 1'b1;
        end else begin
            data_next = s2_sign ? (~s2_mag[OUT_W-1:0] + 1'b1) : s2_mag[OUT_W-1:0];
            udf_next  = (s2_mag[OUT_W-1:0] == '0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
            out_udf   <= 1'b0;
        end else if (adv) begin
            out_valid <= s2_valid;
            out_data  <= data_next;
            out_ovf   <= ovf_next;
            out_udf   <= udf_next;
        end
    end

endmodule

// File: tb/tb_fp27_to_fix.sv
// Directed bench for fp27_to_fix (OUT_W=32, FRAC_BITS=16); expectations are hand-computed.
// Rounding-dependent expectations follow FP2FIX_ROUND_EN.
module tb_fp27_to_fix;

    logic        tst_clk = 1'b0;
    logic        rst;
    logic [26:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_ovf;
    logic        out_udf;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 tst_clk = ~tst_clk;

    fp27_to_fix #(.OUT_W(32), .FRAC_BITS(16)) dut (
        .clk       (tst_clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ovf   (out_ovf),
        .out_udf   (out_udf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic tick;
        @(posedge tst_clk);
        #1;
    endtask

    function automatic logic [26:0] fp(input logic s, input logic [7:0] e, input logic [17:0] m);
        return {s, e, m};
    endfunction

    // Single beat with out_ready held high; waits are bounded
    task automatic convert(input string tag, input logic [26:0] d, input logic [31:0] exp_d,
                           input logic exp_o, input logic exp_u);
        int c;
        in_data  = d;
        in_valid = 1'b1;
        c = 0;
        while (!in_ready && c < 20) begin tick; c++; end
        tick;
        in_valid = 1'b0;
        c = 0;
        while (!out_valid && c < 20) begin tick; c++; end
        check({tag, "_valid"}, 64'(out_valid), 64'd1);
        check({tag, "_data"},  64'(out_data),  64'(exp_d));
        check({tag, "_ovf"},   64'(out_ovf),   64'(exp_o));
        check({tag, "_udf"},   64'(out_udf),   64'(exp_u));
        tick;
    endtask

    logic [26:0] bp_in  [4];
    logic [31:0] bp_exp [4];
    logic        acc;
    logic        stale;
    int          k;

    initial begin
        bp_in[0] = fp(1'b0, 8'd127, 18'h00000);  bp_exp[0] = 32'h00010000;
        bp_in[1] = fp(1'b0, 8'd128, 18'h00000);  bp_exp[1] = 32'h00020000;
        bp_in[2] = fp(1'b0, 8'd128, 18'h20000);  bp_exp[2] = 32'h00030000;
        bp_in[3] = fp(1'b0, 8'd129, 18'h00000);  bp_exp[3] = 32'h00040000;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_flags",     64'({out_ovf, out_udf}), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        rst = 1'b0;
        tick;

        // 2.5 with exact latency: output visible after the third edge counting the accept
        in_data  = fp(1'b0, 8'd128, 18'h10000);
        in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        check("lat_e1_valid", 64'(out_valid), 64'd0);
        tick;
        check("lat_e2_valid", 64'(out_valid), 64'd0);
        tick;
        check("lat_e3_valid", 64'(out_valid), 64'd1);
        check("p2_5_data",    64'(out_data),  64'h00028000);
        check("p2_5_flags",   64'({out_ovf, out_udf}), 64'd0);
        tick;

        convert("m2_5", fp(1'b1, 8'd128, 18'h10000), 32'hFFFD8000, 1'b0, 1'b0);

        // Back-to-back 2.5 then 6.0
        in_data  = fp(1'b0, 8'd128, 18'h10000);
        in_valid = 1'b1;
        tick;
        in_data  = fp(1'b0, 8'd129, 18'h20000);
        tick;
        in_valid = 1'b0;
        tick;
        check("b2b_first_valid", 64'(out_valid), 64'd1);
        check("b2b_first_data",  64'(out_data),  64'h00028000);
        tick;
        check("b2b_second_valid", 64'(out_valid), 64'd1);
        check("b2b_second_data",  64'(out_data),  64'h00060000);
        tick;
        check("b2b_drained", 64'(out_valid), 64'd0);

        convert("p1_0",     fp(1'b0, 8'd127, 18'h00000), 32'h00010000, 1'b0, 1'b0);
        convert("m1_0",     fp(1'b1, 8'd127, 18'h00000), 32'hFFFF0000, 1'b0, 1'b0);
        convert("exp200_p", fp(1'b0, 8'd200, 18'h00000), 32'h7FFFFFFF, 1'b1, 1'b0);
        convert("exp200_n", fp(1'b1, 8'd200, 18'h00000), 32'h80000000, 1'b1, 1'b0);
        convert("m32768",   fp(1'b1, 8'd142, 18'h00000), 32'h80000000, 1'b0, 1'b0);
        convert("p32768",   fp(1'b0, 8'd142, 18'h00000), 32'h7FFFFFFF, 1'b1, 1'b0);
        convert("inf_p",    fp(1'b0, 8'd255, 18'h00000), 32'h7FFFFFFF, 1'b1, 1'b0);
        convert("nan_n",    fp(1'b1, 8'd255, 18'h00001), 32'h80000000, 1'b1, 1'b0);
        convert("exp100",   fp(1'b0, 8'd100, 18'h00000), 32'h00000000, 1'b0, 1'b1);
        convert("denorm",   fp(1'b0, 8'd0,   18'h01234), 32'h00000000, 1'b0, 1'b0);
        convert("neg_zero", fp(1'b1, 8'd0,   18'h00000), 32'h00000000, 1'b0, 1'b0);
        convert("lsb",      fp(1'b0, 8'd111, 18'h00000), 32'h00000001, 1'b0, 1'b0);
`ifdef FP2FIX_ROUND_EN
        convert("one_ulp",  fp(1'b0, 8'd127, 18'h00002), 32'h00010001, 1'b0, 1'b0);
        convert("half_lsb", fp(1'b0, 8'd110, 18'h00000), 32'h00000001, 1'b0, 1'b0);
`else
        convert("one_ulp",  fp(1'b0, 8'd127, 18'h00002), 32'h00010000, 1'b0, 1'b0);
        convert("half_lsb", fp(1'b0, 8'd110, 18'h00000), 32'h00000000, 1'b0, 1'b1);
`endif

        // Backpressure: three beats fill the pipe, the fourth waits at the input
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_data  = bp_in[i];
            in_valid = 1'b1;
            check("bp_fill_in_ready", 64'(in_ready), 64'd1);
            tick;
        end
        in_data  = bp_in[3];
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            check("bp_hold_valid", 64'(out_valid), 64'd1);
            check("bp_hold_data",  64'(out_data),  64'(bp_exp[0]));
            check("bp_in_ready",   64'(in_ready),  64'd0);
            tick;
        end
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 12 && k < 4; c++) begin
            if (out_valid) begin
                check("bp_order", 64'(out_data), 64'(bp_exp[k]));
                k++;
            end
            acc = in_valid && in_ready;
            tick;
            if (acc) in_valid = 1'b0;
        end
        check("bp_count", 64'(k), 64'd4);
        in_valid = 1'b0;
        tick;
        check("bp_drained", 64'(out_valid), 64'd0);

        // Reset mid-stream
        in_data  = fp(1'b0, 8'd128, 18'h00000);
        in_valid = 1'b1;
        tick;
        tick;
        tick;
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        #2;
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_async_valid", 64'(out_valid), 64'd0);
        check("rst_async_data",  64'(out_data),  64'd0);
        check("rst_async_ready", 64'(in_ready),  64'd1);
        tick;
        tick;
        rst   = 1'b0;
        stale = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick;
            if (out_valid) stale = 1'b1;
        end
        check("rst_no_stale", 64'(stale), 64'd0);
        convert("post_rst", fp(1'b0, 8'd127, 18'h00000), 32'h00010000, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
